toggle_activity_accumulator: RTL

- Consumer end of the gate-level activity capture flow. The MIPS_32 simulation and dump side produces per-cycle signal snapshots; this block ingests them and converts them to switching activity in hardware.
- Each accepted sample is XORed with the previous sample. The toggles are counted and weighted by a per-toggle energy weight, then accumulated over a fixed window of samples.
- One summary record per window is emitted on a valid/ready output for the power-estimation datapath.

---
 rtl/toggle_activity_accumulator.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/toggle_activity_accumulator.sv
// toggle_activity_accumulator
// Ingests per-cycle signal snapshots, counts bit toggles between consecutive
// accepted samples, weights them by a per-sample energy weight and reports one
// saturating summary record per WINDOW counted samples.
// Optional feature macro: TOGGLE_PEAK_EN (per-window peak toggle count on
// m_peak; when undefined m_peak is tied to zero and no peak logic exists).
module toggle_activity_accumulator #(
    parameter int SIG_W  = 32,
    parameter int WINDOW = 64,
    parameter int WGT_W  = 8,
    parameter int ACC_W  = 32,
    localparam int PK_W  = $clog2(SIG_W + 1)
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [SIG_W-1:0] s_data,
    input  logic [WGT_W-1:0] cap_weight,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ACC_W-1:0] m_toggles,
    output logic [ACC_W-1:0] m_energy,
    output logic             m_sat,
    output logic [PK_W-1:0]  m_peak
);

    localparam int CNT_W  = $clog2(WINDOW + 1);
    localparam int PROD_W = PK_W + WGT_W;
    // One spare bit above the widest operand so an overflowing sum is visible.
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
    localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({ACC_W{1'b1}});

    // PRIME doubles as the "not yet primed" flag: no separate primed register.
    typedef enum logic [1:0] {
        PRIME  = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [SIG_W-1:0] prev_reg;
    logic [CNT_W-1:0] count_reg;
    logic [ACC_W-1:0] tog_acc_reg;
    logic [ACC_W-1:0] en_acc_reg;
    logic             sat_reg;

    logic [SIG_W-1:0]  diff_bits;
    logic [PK_W-1:0]   toggle_cnt;
    logic [PROD_W-1:0] energy_inc;
    logic [SUM_W-1:0]  tog_sum;
    logic [SUM_W-1:0]  en_sum;
    logic              tog_ovf;
    logic              en_ovf;
    logic [ACC_W-1:0]  tog_acc_next;
    logic [ACC_W-1:0]  en_acc_next;

    logic accept;
    logic counted;
    logic window_done;
    logic handshake;

    assign accept      = s_valid && s_ready;
    assign counted     = accept && (state_reg == ACCUM);
    assign window_done = counted && (count_reg == CNT_W'(WINDOW - 1));
    assign handshake   = m_valid && m_ready;

    // Per-bit toggle detection against the previously accepted sample.
    generate
        for (genvar gi = 0; gi < SIG_W; gi++) begin : g_diff
            assign diff_bits[gi] = s_data[gi] ^ prev_reg[gi];
        end
    endgenerate

    // Popcount of toggled bits, weighted energy and saturating sums.
    always_comb begin
        toggle_cnt = '0;
        for (int i = 0; i < SIG_W; i++) begin
            toggle_cnt = toggle_cnt + PK_W'(diff_bits[i]);
        end
        energy_inc   = PROD_W'(toggle_cnt) * PROD_W'(cap_weight);
        tog_sum      = SUM_W'(tog_acc_reg) + SUM_W'(toggle_cnt);
        en_sum       = SUM_W'(en_acc_reg) + SUM_W'(energy_inc);
        tog_ovf      = (tog_sum > ACC_MAX);
        en_ovf       = (en_sum > ACC_MAX);
        tog_acc_next = tog_ovf ? {ACC_W{1'b1}} : tog_sum[ACC_W-1:0];
        en_acc_next  = en_ovf ? {ACC_W{1'b1}} : en_sum[ACC_W-1:0];
    end

    // FSM state register.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_reg <= PRIME;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state: prime once, accumulate WINDOW samples, hold the report.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            PRIME:   if (accept)      state_next = ACCUM;
            ACCUM:   if (window_done) state_next = REPORT;
            REPORT:  if (handshake)   state_next = ACCUM;
            default:                  state_next = PRIME;
        endcase
    end

    // FSM outputs: input side stalls while a report is pending and during reset.
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        if (!rst && (state_reg != REPORT)) begin
            s_ready = 1'b1;
        end
        if (state_reg == REPORT) begin
            m_valid = 1'b1;
        end
    end

    // Datapath: previous sample, window count and saturating accumulators.
    always_ff @(posedge clk1) begin
        if (rst) begin
            prev_reg    <= '0;
            count_reg   <= '0;
            tog_acc_reg <= '0;
            en_acc_reg  <= '0;
            sat_reg     <= 1'b0;
        end else begin
            if (accept) begin
                prev_reg <= s_data;
            end
            if (counted) begin
                tog_acc_reg <= tog_acc_next;
                en_acc_reg  <= en_acc_next;
                sat_reg     <= sat_reg | tog_ovf | en_ovf;
                count_reg   <= count_reg + CNT_W'(1);
            end
            // prev_reg survives the handshake so the next window continues
            // from the last sample of this one.
            if (handshake) begin
                count_reg   <= '0;
                tog_acc_reg <= '0;
                en_acc_reg  <= '0;
                sat_reg     <= 1'b0;
            end
        end
    end

    assign m_toggles = tog_acc_reg;
    assign m_energy  = en_acc_reg;
    assign m_sat     = sat_reg;

`ifdef TOGGLE_PEAK_EN
    logic [PK_W-1:0] peak_reg;

    // Peak per-sample toggle count over the counted samples of this window.
    always_ff @(posedge clk1) begin
        if (rst) begin
            peak_reg <= '0;
        end else if (handshake) begin
            peak_reg <= '0;
        end else if (counted && (toggle_cnt > peak_reg)) begin
            peak_reg <= toggle_cnt;
        end
    end

    assign m_peak = peak_reg;
`else
    assign m_peak = '0;
`endif

endmodule
